// File: rtl/rv64_exe_pkg.sv
// Shared widths, ALU op codes and the ID/EXE payload for the RV64 execute stage.
package rv64_exe_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned OPW  = 12;
  localparam int unsigned REGW = 5;
  localparam int unsigned SELW = 2;
  localparam int unsigned INSTW = 32;

  localparam logic [OPW-1:0] OP_NOP  = 12'd0;
  localparam logic [OPW-1:0] OP_ADD  = 12'd1;
  localparam logic [OPW-1:0] OP_SUB  = 12'd2;
  localparam logic [OPW-1:0] OP_SLL  = 12'd3;
  localparam logic [OPW-1:0] OP_SLT  = 12'd4;
  localparam logic [OPW-1:0] OP_SLTU = 12'd5;
  localparam logic [OPW-1:0] OP_XOR  = 12'd6;
  localparam logic [OPW-1:0] OP_SRL  = 12'd7;
  localparam logic [OPW-1:0] OP_SRA  = 12'd8;
  localparam logic [OPW-1:0] OP_OR   = 12'd9;
  localparam logic [OPW-1:0] OP_AND  = 12'd10;
  localparam logic [OPW-1:0] OP_ADDW = 12'd11;
  localparam logic [OPW-1:0] OP_SUBW = 12'd12;
  localparam logic [OPW-1:0] OP_SLLW = 12'd13;
  localparam logic [OPW-1:0] OP_SRLW = 12'd14;
  localparam logic [OPW-1:0] OP_SRAW = 12'd15;
  localparam logic [OPW-1:0] OP_LUI  = 12'd16;
  localparam logic [OPW-1:0] OP_LINK = 12'd17;
  localparam logic [OPW-1:0] OP_MEM  = 12'd18;

  localparam logic [INSTW-1:0] BUBBLE_INST = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [OPW-1:0]  op;
    logic [REGW-1:0] rd;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [XLEN-1:0] src1_rs1;
    logic [XLEN-1:0] src2_rs2;
    logic [XLEN-1:0] imm;
    logic [SELW-1:0] src1_sel;
    logic [SELW-1:0] src2_sel;
    logic [SELW-1:0] load_sel;
    logic            data_wen;
    logic            data_ren;
    logic            reg_wen;
  } id_exe_t;

  // Sign-extend a 32-bit W-op result to the full datapath.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/rv64_alu.sv
// Combinational RV64 ALU: result by op code plus an always-computed memory address.
module rv64_alu
  import rv64_exe_pkg::*;
(
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic [XLEN-1:0] data_rd_c,
  output logic [31:0]     ram_addr_c
);

  logic [XLEN-1:0] sum_c;
  logic [31:0]     w_res_c;

  always_comb begin
    sum_c      = src1 + src2;
    ram_addr_c = sum_c[31:0];
    w_res_c    = '0;
    data_rd_c  = '0;
    case (op)
      OP_ADD:  data_rd_c = sum_c;
      OP_SUB:  data_rd_c = src1 - src2;
      OP_SLL:  data_rd_c = src1 << src2[5:0];
      OP_SLT:  data_rd_c = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      OP_SLTU: data_rd_c = {{(XLEN-1){1'b0}}, src1 < src2};
      OP_XOR:  data_rd_c = src1 ^ src2;
      OP_SRL:  data_rd_c = src1 >> src2[5:0];
      OP_SRA:  data_rd_c = XLEN'($signed(src1) >>> src2[5:0]);
      OP_OR:   data_rd_c = src1 | src2;
      OP_AND:  data_rd_c = src1 & src2;
      // W ops work on the low word and sign-extend bit 31 of the result
      OP_ADDW: begin
        w_res_c   = src1[31:0] + src2[31:0];
        data_rd_c = sext32(w_res_c);
      end
      OP_SUBW: begin
        w_res_c   = src1[31:0] - src2[31:0];
        data_rd_c = sext32(w_res_c);
      end
      OP_SLLW: begin
        w_res_c   = src1[31:0] << src2[4:0];
        data_rd_c = sext32(w_res_c);
      end
      OP_SRLW: begin
        w_res_c   = src1[31:0] >> src2[4:0];
        data_rd_c = sext32(w_res_c);
      end
      OP_SRAW: begin
        w_res_c   = 32'($signed(src1[31:0]) >>> src2[4:0]);
        data_rd_c = sext32(w_res_c);
      end
      OP_LUI:  data_rd_c = src2;
      OP_LINK: data_rd_c = src1 + XLEN'(4);
      OP_MEM:  data_rd_c = sum_c;
      default: data_rd_c = '0;
    endcase
  end

endmodule

// File: rtl/rv64_exe_stage.sv
// RV64 execute stage: ID/EXE pipeline register, ALU, and a one-cycle ID tracker for the harness.
module rv64_exe_stage
  import rv64_exe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [OPW-1:0]    id_op,
  input  logic [REGW-1:0]   id_rd,
  input  logic [REGW-1:0]   id_rs1,
  input  logic [REGW-1:0]   id_rs2,
  input  logic [XLEN-1:0]   id_src1_rs1,
  input  logic [XLEN-1:0]   id_src2_rs2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [SELW-1:0]   id_src1_sel,
  input  logic [SELW-1:0]   id_src2_sel,
  input  logic [SELW-1:0]   id_load_sel,
  input  logic              id_data_wen,
  input  logic              id_data_ren,
  input  logic              id_reg_wen,
  output logic [XLEN-1:0]   exe_pc,
  output logic [OPW-1:0]    exe_op,
  output logic [REGW-1:0]   exe_rd,
  output logic [REGW-1:0]   exe_rs1,
  output logic [REGW-1:0]   exe_rs2,
  output logic [XLEN-1:0]   exe_src1_rs1,
  output logic [XLEN-1:0]   exe_src2_rs2,
  output logic [XLEN-1:0]   exe_imm,
  output logic [SELW-1:0]   exe_src1_sel,
  output logic [SELW-1:0]   exe_src2_sel,
  output logic [SELW-1:0]   exe_load_sel,
  output logic              exe_data_wen,
  output logic              exe_data_ren,
  output logic              exe_reg_wen,
  input  logic [XLEN-1:0]   alu_src1,
  input  logic [XLEN-1:0]   alu_src2,
  output logic [XLEN-1:0]   alu_data_rd,
  output logic [31:0]       alu_ram_addr,
  input  logic [INSTW-1:0]  id_inst,
  input  logic              id_ebreak,
  output logic [INSTW-1:0]  trk_inst,
  output logic [OPW-1:0]    trk_op,
  output logic              trk_ebreak
);

  id_exe_t          pipe_d, pipe_q;
  logic [INSTW-1:0] trk_inst_d, trk_inst_q;
  logic [OPW-1:0]   trk_op_d, trk_op_q;
  logic             trk_ebreak_d, trk_ebreak_q;

  always_comb begin
    pipe_d.pc       = id_pc;
    pipe_d.op       = id_op;
    pipe_d.rd       = id_rd;
    pipe_d.rs1      = id_rs1;
    pipe_d.rs2      = id_rs2;
    pipe_d.src1_rs1 = id_src1_rs1;
    pipe_d.src2_rs2 = id_src2_rs2;
    pipe_d.imm      = id_imm;
    pipe_d.src1_sel = id_src1_sel;
    pipe_d.src2_sel = id_src2_sel;
    pipe_d.load_sel = id_load_sel;
    pipe_d.data_wen = id_data_wen;
    pipe_d.data_ren = id_data_ren;
    pipe_d.reg_wen  = id_reg_wen;
    trk_inst_d      = id_inst;
    trk_op_d        = id_op;
    trk_ebreak_d    = id_ebreak;
  end

  // Reset clears the payload to a NOP; the tracker shows the bubble marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_q       <= '0;
      trk_inst_q   <= BUBBLE_INST;
      trk_op_q     <= '0;
      trk_ebreak_q <= 1'b0;
    end else begin
      pipe_q       <= pipe_d;
      trk_inst_q   <= trk_inst_d;
      trk_op_q     <= trk_op_d;
      trk_ebreak_q <= trk_ebreak_d;
    end
  end

  assign exe_pc       = pipe_q.pc;
  assign exe_op       = pipe_q.op;
  assign exe_rd       = pipe_q.rd;
  assign exe_rs1      = pipe_q.rs1;
  assign exe_rs2      = pipe_q.rs2;
  assign exe_src1_rs1 = pipe_q.src1_rs1;
  assign exe_src2_rs2 = pipe_q.src2_rs2;
  assign exe_imm      = pipe_q.imm;
  assign exe_src1_sel = pipe_q.src1_sel;
  assign exe_src2_sel = pipe_q.src2_sel;
  assign exe_load_sel = pipe_q.load_sel;
  assign exe_data_wen = pipe_q.data_wen;
  assign exe_data_ren = pipe_q.data_ren;
  assign exe_reg_wen  = pipe_q.reg_wen;
  assign trk_inst     = trk_inst_q;
  assign trk_op       = trk_op_q;
  assign trk_ebreak   = trk_ebreak_q;

  rv64_alu u_alu (
    .op         (pipe_q.op),
    .src1       (alu_src1),
    .src2       (alu_src2),
    .data_rd_c  (alu_data_rd),
    .ram_addr_c (alu_ram_addr)
  );

endmodule

// File: tb/tb_rv64_exe_stage.sv
// Self-checking bench for rv64_exe_stage: directed vectors, corner sequences, random vs reference model.
module tb_rv64_exe_stage;

  logic        clk;
  logic        rst;
  logic [63:0] id_pc, exe_pc;
  logic [11:0] id_op, exe_op;
  logic [4:0]  id_rd, id_rs1, id_rs2, exe_rd, exe_rs1, exe_rs2;
  logic [63:0] id_src1_rs1, id_src2_rs2, id_imm, exe_src1_rs1, exe_src2_rs2, exe_imm;
  logic [1:0]  id_src1_sel, id_src2_sel, id_load_sel, exe_src1_sel, exe_src2_sel, exe_load_sel;
  logic        id_data_wen, id_data_ren, id_reg_wen, exe_data_wen, exe_data_ren, exe_reg_wen;
  logic [63:0] alu_src1, alu_src2, alu_data_rd;
  logic [31:0] alu_ram_addr;
  logic [31:0] id_inst, trk_inst;
  logic        id_ebreak, trk_ebreak;
  logic [11:0] trk_op;

  int n_checks = 0;
  int n_fail   = 0;

  rv64_exe_stage dut (
    .clk(clk), .rst(rst),
    .id_pc(id_pc), .id_op(id_op), .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_src1_rs1(id_src1_rs1), .id_src2_rs2(id_src2_rs2), .id_imm(id_imm),
    .id_src1_sel(id_src1_sel), .id_src2_sel(id_src2_sel), .id_load_sel(id_load_sel),
    .id_data_wen(id_data_wen), .id_data_ren(id_data_ren), .id_reg_wen(id_reg_wen),
    .exe_pc(exe_pc), .exe_op(exe_op), .exe_rd(exe_rd), .exe_rs1(exe_rs1), .exe_rs2(exe_rs2),
    .exe_src1_rs1(exe_src1_rs1), .exe_src2_rs2(exe_src2_rs2), .exe_imm(exe_imm),
    .exe_src1_sel(exe_src1_sel), .exe_src2_sel(exe_src2_sel), .exe_load_sel(exe_load_sel),
    .exe_data_wen(exe_data_wen), .exe_data_ren(exe_data_ren), .exe_reg_wen(exe_reg_wen),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_data_rd(alu_data_rd), .alu_ram_addr(alu_ram_addr),
    .id_inst(id_inst), .id_ebreak(id_ebreak),
    .trk_inst(trk_inst), .trk_op(trk_op), .trk_ebreak(trk_ebreak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned op;
    logic [63:0] s1;
    logic [63:0] s2;
    logic [63:0] rd;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [291:0] exe_cat();
    return {exe_pc, exe_op, exe_rd, exe_rs1, exe_rs2, exe_src1_rs1, exe_src2_rs2, exe_imm,
            exe_src1_sel, exe_src2_sel, exe_load_sel, exe_data_wen, exe_data_ren, exe_reg_wen};
  endfunction

  function automatic logic [291:0] id_cat();
    return {id_pc, id_op, id_rd, id_rs1, id_rs2, id_src1_rs1, id_src2_rs2, id_imm,
            id_src1_sel, id_src2_sel, id_load_sel, id_data_wen, id_data_ren, id_reg_wen};
  endfunction

  // Reference ALU expressed with signed/unsigned integer arithmetic on the architectural rules.
  function automatic logic [63:0] ref_alu(input int unsigned op, input logic [63:0] a, input logic [63:0] b);
    longint      sa = longint'(a);
    longint      sb = longint'(b);
    logic [31:0] wa = a[31:0];
    logic [31:0] wb = b[31:0];
    int          w;
    case (op)
      1:  return a + b;
      2:  return a - b;
      3:  return a << b[5:0];
      4:  return (sa < sb) ? 64'd1 : 64'd0;
      5:  return (a < b) ? 64'd1 : 64'd0;
      6:  return a ^ b;
      7:  return a >> b[5:0];
      8:  return 64'(sa >>> b[5:0]);
      9:  return a | b;
      10: return a & b;
      11: begin w = int'(wa + wb);               return 64'(longint'(w)); end
      12: begin w = int'(wa - wb);               return 64'(longint'(w)); end
      13: begin w = int'(wa << b[4:0]);          return 64'(longint'(w)); end
      14: begin w = int'(wa >> b[4:0]);          return 64'(longint'(w)); end
      15: begin w = int'(wa) >>> b[4:0];         return 64'(longint'(w)); end
      16: return b;
      17: return a + 64'd4;
      18: return a + b;
      default: return 64'd0;
    endcase
  endfunction

  task automatic add_vec(input string n, input int unsigned op, input logic [63:0] s1,
                         input logic [63:0] s2, input logic [63:0] rd, input logic [31:0] addr);
    vec_t v;
    v.name = n; v.op = op; v.s1 = s1; v.s2 = s2; v.rd = rd; v.addr = addr;
    vecs.push_back(v);
  endtask

  task automatic clear_id();
    id_pc = '0; id_op = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    id_src1_rs1 = '0; id_src2_rs2 = '0; id_imm = '0;
    id_src1_sel = '0; id_src2_sel = '0; id_load_sel = '0;
    id_data_wen = 1'b0; id_data_ren = 1'b0; id_reg_wen = 1'b0;
    id_inst = '0; id_ebreak = 1'b0;
  endtask

  task automatic rand_id();
    id_pc = {$urandom, $urandom}; id_rd = 5'($urandom); id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
    id_src1_rs1 = {$urandom, $urandom}; id_src2_rs2 = {$urandom, $urandom}; id_imm = {$urandom, $urandom};
    id_src1_sel = 2'($urandom); id_src2_sel = 2'($urandom); id_load_sel = 2'($urandom);
    id_data_wen = 1'($urandom); id_data_ren = 1'($urandom); id_reg_wen = 1'($urandom);
    id_inst = $urandom; id_ebreak = 1'($urandom);
    id_op = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 20));
  endtask

  initial begin
    logic [291:0] saved_id;
    logic [31:0]  saved_inst;
    logic         saved_ebreak;

    add_vec("add_wrap",  1,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 32'h0);
    add_vec("sub_under", 2,  64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h1);
    add_vec("addw_ovf",  11, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 32'h8000_0000);
    add_vec("sra_63",    8,  64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 32'h3F);
    add_vec("slt_neg",   4,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 32'h0);
    add_vec("sltu_neg",  5,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 32'h0);
    add_vec("slt_pos",   4,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 32'h0);
    add_vec("srlw",      14, 64'hFFFF_FFFF_8000_0000, 64'd4, 64'h0000_0000_0800_0000, 32'h8000_0004);
    add_vec("mem_addr",  18, 64'h8000_1000, 64'hFFFF_FFFF_FFFF_FFF8, 64'h8000_0FF8, 32'h8000_0FF8);
    add_vec("nop",       0,  64'd5, 64'd6, 64'd0, 32'd11);
    add_vec("link",      17, 64'h8000_0000, 64'd0, 64'h8000_0004, 32'h8000_0000);
    add_vec("lui",       16, 64'd1, 64'hDEAD, 64'hDEAD, 32'hDEAE);
    add_vec("sllw_b31",  13, 64'd1, 64'd31, 64'hFFFF_FFFF_8000_0000, 32'h20);
    add_vec("sraw",      15, 64'h8000_0000, 64'd4, 64'hFFFF_FFFF_F800_0000, 32'h8000_0004);
    add_vec("subw",      12, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'h1);
    add_vec("sll_mask",  3,  64'd1, 64'h43, 64'd8, 32'h44);
    add_vec("srl_60",    7,  64'hFFFF_FFFF_FFFF_FFFF, 64'd60, 64'hF, 32'h3B);
    add_vec("xor",       6,  64'hF0F0, 64'hFF00, 64'h0FF0, 32'h1EFF0);
    add_vec("or",        9,  64'hF0F0, 64'hFF00, 64'hFFF0, 32'h1EFF0);
    add_vec("and",       10, 64'hF0F0, 64'hFF00, 64'hF000, 32'h1EFF0);
    add_vec("undef_op",  19, 64'd1, 64'd2, 64'd0, 32'h3);

    clear_id();
    alu_src1 = 64'd7;
    alu_src2 = 64'd9;
    rst = 1'b1;
    #2;
    check("reset_exe", 320'(exe_cat()), 320'(0));
    check("reset_trk", 320'({trk_inst, trk_op, trk_ebreak}), 320'({32'hFFFF_FFFF, 12'd0, 1'b0}));
    check("reset_alu_rd", 320'(alu_data_rd), 320'(0));
    @(negedge clk);
    rst = 1'b0;

    // Register timing: new ID values must not appear until the next edge.
    tick();
    id_pc = 64'h8000_0004; id_op = 12'd1; id_rd = 5'd5; id_reg_wen = 1'b1;
    #1;
    check("pre_edge_exe", 320'({exe_pc, exe_op, exe_rd, exe_reg_wen}), 320'(0));
    tick();
    check("post_edge_exe", 320'({exe_pc, exe_op, exe_rd, exe_reg_wen}),
          320'({64'h8000_0004, 12'd1, 5'd5, 1'b1}));

    // Tracker captures an ebreak.
    id_inst = 32'h0010_0073; id_ebreak = 1'b1; id_op = 12'd0;
    tick();
    check("trk_ebreak", 320'({trk_inst, trk_op, trk_ebreak}), 320'({32'h0010_0073, 12'd0, 1'b1}));

    // Mid-cycle async reset with a fully loaded pipeline.
    rand_id();
    id_op = 12'd1;
    tick();
    check("loaded_exe", 320'(exe_cat()), 320'(id_cat()));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_exe", 320'(exe_cat()), 320'(0));
    check("async_rst_trk", 320'({trk_inst, trk_op, trk_ebreak}), 320'({32'hFFFF_FFFF, 12'd0, 1'b0}));
    check("async_rst_alu", 320'(alu_data_rd), 320'(0));
    @(negedge clk);
    rst = 1'b0;
    clear_id();

    foreach (vecs[i]) begin
      id_op = 12'(vecs[i].op);
      tick();
      alu_src1 = vecs[i].s1;
      alu_src2 = vecs[i].s2;
      #1;
      check({vecs[i].name, "_rd"}, 320'(alu_data_rd), 320'(vecs[i].rd));
      check({vecs[i].name, "_addr"}, 320'(alu_ram_addr), 320'(vecs[i].addr));
    end

    for (int n = 0; n < 300; n++) begin
      rand_id();
      saved_id     = id_cat();
      saved_inst   = id_inst;
      saved_ebreak = id_ebreak;
      tick();
      alu_src1 = {$urandom, $urandom};
      alu_src2 = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 70)) : {$urandom, $urandom};
      #1;
      check("rand_pipe", 320'(exe_cat()), 320'(saved_id));
      check("rand_trk", 320'({trk_inst, trk_op, trk_ebreak}),
            320'({saved_inst, saved_id[227:216], saved_ebreak}));
      check("rand_alu_rd", 320'(alu_data_rd), 320'(ref_alu(int'(saved_id[227:216]), alu_src1, alu_src2)));
      check("rand_alu_addr", 320'(alu_ram_addr), 320'(32'(alu_src1 + alu_src2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv64_exe_stage.md
Name: rv64_exe_stage

Overview:
- RV64 execute stage of the 5-stage pipeline, sitting between decode (ID) and memory (MEM).
- Contains the ID/EXE pipeline register and a combinational ALU. The ALU is driven by the registered op and by operands forwarded from outside the block.
- Also contains a one-cycle ID-stage tracker (inst/op/ebreak) that the simulation harness uses for trap and unimplemented-instruction detection.

Parameters:
- XLEN, 64, datapath width.
- OPW, 12, width of the ALU op code.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_pc / exe_pc  in/out  64  instruction PC.
- id_op / exe_op  in/out  12  ALU op code.
- id_rd, id_rs1, id_rs2 / exe_rd, exe_rs1, exe_rs2  in/out  5 each  register indices.
- id_src1_rs1, id_src2_rs2 / exe_src1_rs1, exe_src2_rs2  in/out  64  register-file read data.
- id_imm / exe_imm  in/out  64  immediate.
- id_src1_sel, id_src2_sel, id_load_sel / exe_*  in/out  2 each  operand and write-back selects.
- id_data_wen, id_data_ren, id_reg_wen / exe_*  in/out  1 each  memory write, memory read, register write enables.
- alu_src1, alu_src2  in  64  post-forwarding ALU operands.
- alu_data_rd  out  64  ALU result.
- alu_ram_addr  out  32  memory address.
- id_inst  in  32  ID-stage instruction.
- id_ebreak  in  1  decoded ebreak.
- trk_inst  out  32  id_inst delayed one cycle.
- trk_op  out  12  id_op delayed one cycle.
- trk_ebreak  out  1  id_ebreak delayed one cycle.

Behaviour:
- Pipeline register:
  - Every rising clk, each exe_* output takes its id_* input; latency 1 cycle.
  - No enable and no flush input. Bubbles are injected upstream by zeroing the enables.
  - rst (async) forces every exe_* output to 0. op 0 = NOP.
- Tracker:
  - Every rising clk: trk_inst<=id_inst, trk_op<=id_op, trk_ebreak<=id_ebreak.
  - On rst: trk_inst=32'hFFFF_FFFF (bubble marker), trk_op=0, trk_ebreak=0.
- ALU (purely combinational, from exe_op, alu_src1, alu_src2):
  - alu_ram_addr = (alu_src1+alu_src2)[31:0] for every op.
  - alu_data_rd by exe_op:
    - 0 NOP: result 0.
    - 1 ADD: s1+s2.
    - 2 SUB: s1-s2.
    - 3 SLL: s1<<s2[5:0].
    - 4 SLT: signed compare, result 1/0.
    - 5 SLTU: unsigned compare, result 1/0.
    - 6 XOR, 9 OR, 10 AND: bitwise.
    - 7 SRL: logical s1>>s2[5:0].
    - 8 SRA: arithmetic s1>>>s2[5:0].
    - 11 ADDW, 12 SUBW: 32-bit add/sub, sign-extended.
    - 13 SLLW, 14 SRLW, 15 SRAW: operate on s1[31:0], shift by s2[4:0], sign-extend bit 31 of the result.
    - 16 LUI/PASS: s2.
    - 17 LINK: s1+4 (s1 = pc, used by JAL/JALR).
    - 18 LOAD/STORE: s1+s2. The address is also driven on alu_ram_addr.
    - Any undefined op: result 0.
- Arithmetic: all arithmetic wraps modulo 2^64 (32 for the W ops); no overflow flags.
- Simultaneous events: rst overrides the clock edge. Deasserting rst mid-cycle takes effect at the next edge.

Decomposition:
- Shared package rv64_exe_pkg holds the op-code localparams (OP_NOP..OP_MEM), XLEN, and BUBBLE_INST=32'hFFFF_FFFF.
- One natural sub-module: rv64_alu (combinational). The register and tracker stay inline in the top level.

Test Plan:
- Reset: assert rst mid-cycle -> all exe_* = 0 immediately, trk_inst=32'hFFFF_FFFF, trk_op=0, trk_ebreak=0, alu_data_rd=0.
- Register timing: id_pc=64'h8000_0004, id_op=1, id_rd=5, id_reg_wen=1 -> after one edge exe_pc=64'h8000_0004, exe_op=1, exe_rd=5, exe_reg_wen=1; the values are not visible before that edge.
- Add/sub boundaries:
  - exe_op=ADD, s1=64'hFFFF_FFFF_FFFF_FFFF, s2=1 -> alu_data_rd=0.
  - SUB with s1=0, s2=1 -> all ones.
  - ADDW with s1=32'h7FFF_FFFF, s2=1 -> 64'hFFFF_FFFF_8000_0000.
- Shifts and compares:
  - SRA with s1=64'h8000_0000_0000_0000, s2=63 -> all ones.
  - SLT with s1=-1, s2=1 -> 1; SLTU with the same operands -> 0.
  - SRLW with s1=64'hFFFF_FFFF_8000_0000, s2=4 -> 64'h0000_0000_0800_0000.
- Memory address: exe_op=MEM, s1=64'h8000_1000, s2=-8 -> alu_ram_addr=32'h8000_0FF8.
- Tracker: id_inst=32'h0010_0073, id_ebreak=1, id_op=0 -> next cycle trk_inst=32'h0010_0073, trk_ebreak=1, trk_op=0.
